// File: rtl/alu_pkg.sv
// Shared opcode and function-select encodings for the ALU, its control decoder
// and the main control unit.
package alu_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b100;
    localparam logic [2:0] OP_MF  = 3'b110;

    localparam logic [2:0] ULA_AND = 3'd0;
    localparam logic [2:0] ULA_OR  = 3'd1;
    localparam logic [2:0] ULA_ADD = 3'd2;
    localparam logic [2:0] ULA_SUB = 3'd3;
    localparam logic [2:0] ULA_SLT = 3'd4;
    localparam logic [2:0] ULA_MF  = 3'd5;

    typedef struct packed {
        logic       opInvalid;
        logic       twoOperands;
        logic [2:0] ulaSel;
    } aluCtrl_t;

endpackage

// File: rtl/controle_alu_dec.sv
// Combinational decode of the ALU operation class into function select and
// operand mode; feeds the output register stage in controle_alu.
module controle_alu_dec
    import alu_pkg::*;
(
    input  logic [2:0] opAlu,
    output aluCtrl_t   ctrlNext
);

    always_comb begin
        // Unassigned codes (and X/Z in simulation) fall through to a harmless ADD.
        ctrlNext.ulaSel      = ULA_ADD;
        ctrlNext.twoOperands = 1'b0;
        ctrlNext.opInvalid   = 1'b1;
        case (opAlu)
            OP_AND: begin
                ctrlNext.ulaSel      = ULA_AND;
                ctrlNext.twoOperands = 1'b1;
                ctrlNext.opInvalid   = 1'b0;
            end
            OP_OR: begin
                ctrlNext.ulaSel      = ULA_OR;
                ctrlNext.twoOperands = 1'b1;
                ctrlNext.opInvalid   = 1'b0;
            end
            OP_ADD: begin
                ctrlNext.ulaSel      = ULA_ADD;
                ctrlNext.twoOperands = 1'b1;
                ctrlNext.opInvalid   = 1'b0;
            end
            OP_SUB: begin
                ctrlNext.ulaSel      = ULA_SUB;
                ctrlNext.twoOperands = 1'b1;
                ctrlNext.opInvalid   = 1'b0;
            end
            OP_SLT: begin
                ctrlNext.ulaSel      = ULA_SLT;
                ctrlNext.twoOperands = 1'b1;
                ctrlNext.opInvalid   = 1'b0;
            end
            OP_MF: begin
                ctrlNext.ulaSel      = ULA_MF;
                ctrlNext.twoOperands = 1'b0;
                ctrlNext.opInvalid   = 1'b0;
            end
            default: begin
                ctrlNext.ulaSel      = ULA_ADD;
                ctrlNext.twoOperands = 1'b0;
                ctrlNext.opInvalid   = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/controle_alu.sv
// ALU control decoder: registered translation of opAlu into sinal_ula,
// twoandOne and op_invalid with one clock of latency.
module controle_alu
    import alu_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic [2:0] opAlu,
    output logic       twoandOne,
    output logic [2:0] sinal_ula,
    output logic       op_invalid
);

    aluCtrl_t ctrlNext;

    controle_alu_dec uDec (
        .opAlu    (opAlu),
        .ctrlNext (ctrlNext)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sinal_ula  <= ULA_AND;
            twoandOne  <= 1'b0;
            op_invalid <= 1'b0;
        end else begin
            sinal_ula  <= ctrlNext.ulaSel;
            twoandOne  <= ctrlNext.twoOperands;
            op_invalid <= ctrlNext.opInvalid;
        end
    end

endmodule

// File: tb/tb_controle_alu.sv
// Directed and random checks of controle_alu against a table reference model.
module tb_controle_alu;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [2:0] opAlu;
    logic       twoandOne;
    logic [2:0] sinal_ula;
    logic       op_invalid;

    int checks = 0;
    int errors = 0;

    controle_alu dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .opAlu      (opAlu),
        .twoandOne  (twoandOne),
        .sinal_ula  (sinal_ula),
        .op_invalid (op_invalid)
    );

    always #5 clock = ~clock;

    task automatic checkVal(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic stepCycle();
        @(posedge clock);
        #1;
    endtask

    // Hand-written decode table, independent of the RTL encoding.
    task automatic refModel(input logic [2:0] op, output logic [2:0] ula,
                            output logic two, output logic inv);
        logic [2:0] ulaTab [8];
        logic [7:0] twoTab;
        logic [7:0] invTab;
        ulaTab = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd2, 3'd5, 3'd2};
        twoTab = 8'b0001_1111;
        invTab = 8'b1010_0000;
        ula = ulaTab[op];
        two = twoTab[op];
        inv = invTab[op];
    endtask

    task automatic checkAll(input string tag, input logic [2:0] ula,
                            input logic two, input logic inv);
        checkVal({tag, ".sinal_ula"},  {5'd0, sinal_ula},  {5'd0, ula});
        checkVal({tag, ".twoandOne"},  {7'd0, twoandOne},  {7'd0, two});
        checkVal({tag, ".op_invalid"}, {7'd0, op_invalid}, {7'd0, inv});
    endtask

    initial begin
        logic [2:0] sweepOps [6];
        logic [2:0] sweepUla [6];
        logic [5:0] sweepTwo;
        logic [2:0] eUla;
        logic       eTwo;
        logic       eInv;
        logic [2:0] pUla;
        logic       pTwo;
        logic       pInv;

        sweepOps = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b110};
        sweepUla = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
        sweepTwo = 6'b01_1111;

        reset_n = 1'b0;
        opAlu   = 3'b011;
        stepCycle();
        stepCycle();
        checkAll("reset", 3'd0, 1'b0, 1'b0);

        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            opAlu = sweepOps[i];
            stepCycle();
            checkAll($sformatf("sweep%0d", i), sweepUla[i], sweepTwo[i], 1'b0);
        end

        opAlu = 3'b101;
        stepCycle();
        checkAll("unassigned101", 3'd2, 1'b0, 1'b1);
        opAlu = 3'b111;
        stepCycle();
        checkAll("unassigned111", 3'd2, 1'b0, 1'b1);

        opAlu   = 3'b100;
        reset_n = 1'b0;
        stepCycle();
        checkAll("midReset", 3'd0, 1'b0, 1'b0);
        reset_n = 1'b1;
        stepCycle();
        checkAll("releaseSlt", 3'd4, 1'b1, 1'b0);

        opAlu = 3'b001;
        for (int i = 0; i < 10; i++) begin
            stepCycle();
            checkAll($sformatf("hold%0d", i), 3'd1, 1'b1, 1'b0);
            #3;
            checkAll($sformatf("holdMid%0d", i), 3'd1, 1'b1, 1'b0);
        end

        // Outputs must still show the previous decode until the next edge.
        pUla = 3'd1;
        pTwo = 1'b1;
        pInv = 1'b0;
        for (int i = 0; i < 200; i++) begin
            opAlu = 3'($urandom_range(0, 7));
            #1;
            checkAll($sformatf("randPrev%0d", i), pUla, pTwo, pInv);
            refModel(opAlu, eUla, eTwo, eInv);
            stepCycle();
            checkAll($sformatf("rand%0d", i), eUla, eTwo, eInv);
            pUla = eUla;
            pTwo = eTwo;
            pInv = eInv;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
